// File: rtl/laser_echo_collector.sv
// Receive-side echo collector: opens STOP1/STOP2 TDC windows per laser shot and issues one tagged record.
// Optional hit counters are built when LASER_ECHO_HITCNT_EN is defined.
module laser_echo_collector #(
    parameter int STOP1_WINDOW = 48,
    parameter int STOP2_WINDOW = 54,
    parameter int DATA_W       = 16
) (
    input  logic              i_clk_100m,
    input  logic              i_rst_n,
    input  logic              i_laser_sync,
    input  logic [3:0]        i_laser_sernum,
    input  logic [3:0]        i_tdc1_chnlmask,
    input  logic [3:0]        i_tdc2_chnlmask,
    input  logic              i_tdc1_valid,
    input  logic [1:0]        i_tdc1_chnl,
    input  logic [DATA_W-1:0] i_tdc1_data,
    input  logic              i_tdc2_valid,
    input  logic [1:0]        i_tdc2_chnl,
    input  logic [DATA_W-1:0] i_tdc2_data,
    input  logic              i_echo_ready,
    output logic              o_cdctdc_ready,
    output logic              o_echo_valid,
    output logic [3:0]        o_echo_sernum,
    output logic [DATA_W-1:0] o_echo_stop1,
    output logic [DATA_W-1:0] o_echo_stop2,
    output logic [1:0]        o_echo_flags,
    output logic [2:0]        o_echo_hitcnt1,
    output logic [2:0]        o_echo_hitcnt2,
    output logic              o_sync_drop
);

    // state     | meaning
    // ST_IDLE   | waiting for a laser sync, emitter may fire
    // ST_WINDOW | acceptance windows open, counter running
    // ST_HOLD   | record presented until downstream accepts it
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(STOP2_WINDOW + 1);
    localparam logic [CNT_W-1:0] LIM1 = CNT_W'(STOP1_WINDOW);
    localparam logic [CNT_W-1:0] LIM2 = CNT_W'(STOP2_WINDOW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STOP2_WINDOW - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       mask1;
    logic [3:0]       mask2;
    logic             start;
    logic             hit1;
    logic             hit2;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_laser_sync) begin
                    state_nxt = ST_WINDOW;
                    start     = 1'b1;
                end
            end
            ST_WINDOW: begin
                if (cnt == LAST) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (o_echo_valid && i_echo_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign hit1 = (state == ST_WINDOW) && i_tdc1_valid && (cnt < LIM1) && mask1[i_tdc1_chnl];
    assign hit2 = (state == ST_WINDOW) && i_tdc2_valid && (cnt < LIM2) && mask2[i_tdc2_chnl];

    // Ready is a flop tracking the next state so it stays low while reset is held.
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            mask1          <= '0;
            mask2          <= '0;
            o_cdctdc_ready <= 1'b0;
            o_echo_valid   <= 1'b0;
            o_echo_sernum  <= '0;
            o_echo_stop1   <= '0;
            o_echo_stop2   <= '0;
            o_echo_flags   <= '0;
            o_sync_drop    <= 1'b0;
        end else begin
            state          <= state_nxt;
            o_cdctdc_ready <= (state_nxt == ST_IDLE);
            o_echo_valid   <= (state_nxt == ST_HOLD);
            o_sync_drop    <= i_laser_sync && (state != ST_IDLE);
            if (start) begin
                cnt           <= '0;
                mask1         <= i_tdc1_chnlmask;
                mask2         <= i_tdc2_chnlmask;
                o_echo_sernum <= i_laser_sernum;
                o_echo_stop1  <= '0;
                o_echo_stop2  <= '0;
                o_echo_flags  <= '0;
            end else if (state == ST_WINDOW) begin
                cnt <= cnt + 1'b1;
                if (hit1 && !o_echo_flags[0]) begin
                    o_echo_stop1    <= i_tdc1_data;
                    o_echo_flags[0] <= 1'b1;
                end
                if (hit2 && !o_echo_flags[1]) begin
                    o_echo_stop2    <= i_tdc2_data;
                    o_echo_flags[1] <= 1'b1;
                end
            end
        end
    end

`ifdef LASER_ECHO_HITCNT_EN
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_echo_hitcnt1 <= '0;
            o_echo_hitcnt2 <= '0;
        end else if (start) begin
            o_echo_hitcnt1 <= '0;
            o_echo_hitcnt2 <= '0;
        end else begin
            if (hit1 && (o_echo_hitcnt1 != 3'd7)) o_echo_hitcnt1 <= o_echo_hitcnt1 + 3'd1;
            if (hit2 && (o_echo_hitcnt2 != 3'd7)) o_echo_hitcnt2 <= o_echo_hitcnt2 + 3'd1;
        end
    end
`else
    assign o_echo_hitcnt1 = 3'd0;
    assign o_echo_hitcnt2 = 3'd0;
`endif

endmodule
